id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the 32x32 register file.
- Takes the RF asynchronous read data (rd0/rd1) plus decoded ID fields and resolves RAW hazards:
  - forwards results from the EX and MEM stages;
  - detects load-use stalls.
- Registers the resolved operands and control for the EX stage, with flush (bubble) and stall handling.
- WB-stage hazards are covered by the RF's negedge write, so no WB bypass is needed here.

Parameters:
- XLEN, 32, datapath width of operands, PC, immediate and forwarded results.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- id_valid  input  1  ID holds a live instruction.
- id_pc  input  XLEN  PC of the ID instruction.
- id_rs1, id_rs2  input  5  source register addresses (also drive RF ra0/ra1).
- id_use1, id_use2  input  1  instruction actually reads rs1/rs2.
- rf_rd1, rf_rd2  input  XLEN  RF read data for rs1/rs2.
- id_imm  input  XLEN  decoded immediate.
- id_rd  input  5  destination register.
- id_we  input  1  writes rd.
- id_load  input  1  is a load.
- id_ctrl  input  8  opaque ALU/branch/mem control, passed through.
- flush  input  1  kill the ID instruction (taken branch/jump from EX).
- e_rd, e_we, e_load, e_res  input  5/1/1/XLEN  instruction now in EX: dest, write enable, load flag, ALU result (combinational).
- m_rd, m_we, m_res  input  5/1/XLEN  instruction now in MEM: dest, write enable, final result (load data or ALU).
- stall_o  output  1  hold PC and IF/ID this cycle.
- q_valid  output  1  EX instruction valid.
- q_pc, q_op1, q_op2, q_imm  output  XLEN  registered EX fields.
- q_rd  output  5  registered dest.
- q_we, q_load  output  1  registered control.
- q_ctrl  output  8  registered control.
- stall_cnt  output  CNT_W  number of stall cycles since reset.

Behaviour:
- Reset (rstn=0, asynchronous): all q_* = 0 and stall_cnt = 0. stall_o is combinational and equals 0 whenever flush=1 or id_valid=0.
- Match rules:
  - match_e(x) = e_we & (e_rd==x) & (x!=0)
  - match_m(x) = m_we & (m_rd==x) & (x!=0)
  - x0 is never forwarded and never causes a stall.
- Operand select (with OPT_FWD_EN), op1 shown; op2 is identical with rs2/rf_rd2/id_use2:
  - if match_e(rs1) & ~e_load: take e_res;
  - else if match_m(rs1): take m_res;
  - else: take rf_rd1.
  - EX has priority over MEM (youngest value wins).
- Hazard:
  - hz = id_valid & ((id_use1 & match_e(rs1) & e_load) | (id_use2 & match_e(rs2) & e_load)).
  - stall_o = hz & ~flush.
- Rising edge, priority order:
  1. flush=1 → bubble: q_valid, q_we, q_load, q_ctrl all cleared; other q_* = 0. flush overrides stall.
  2. stall_o=1 → bubble as above. Upstream holds, so the same instruction re-presents next cycle.
  3. Otherwise → capture:
     - q_valid = id_valid; q_we = id_we & id_valid; q_load = id_load & id_valid;
     - q_op1/q_op2 = selected operands;
     - remaining fields copied.
- Load-use latency:
  - 1 bubble; next cycle the load is in MEM and is forwarded from m_res.
- stall_cnt:
  - +1 on each edge where stall_o=1;
  - saturates at all-ones (no wrap);
  - unaffected by flush.
- Reset mid-stall: stall is dropped immediately; the outputs bubble.

Optional Feature:
- Macro OPT_FWD_EN.
- Defined:
  - forwarding muxes as above;
  - stalls only for load-use.
- Undefined:
  - no bypass; q_op1/q_op2 always come from rf_rd1/rf_rd2;
  - hz additionally covers any used-source match_e or match_m regardless of load, giving up to 2 bubbles per dependency;
  - e_res/m_res are unused.

Test Plan:
- Reset then release; id_valid=0 → q_valid=0, stall_cnt=0, stall_o=0.
- ALU→ALU: e_rd=5, e_we=1, e_res=0x1234, id_rs1=5, id_use1=1, rf_rd1=0 → next edge q_op1=0x1234, stall_o=0 (FWD_EN). Without FWD_EN: stall_o=1, then stall_o=1 again with m_rd=5, then q_op1=rf_rd1.
- Priority: e_rd=m_rd=7, e_res=0xA, m_res=0xB, rs2=7 used → q_op2=0xA. Same with rs2=0 → q_op2=rf_rd2, no stall.
- Load-use: e_load=1, e_rd=3, rs1=3 used → stall_o=1 and q_valid=0 for 1 cycle, stall_cnt=1. Next cycle m_rd=3, m_res=0x55 → q_op1=0x55.
- Flush during hazard: hazard conditions present with flush=1 → stall_o=0, q_valid=0, q_we=0, stall_cnt unchanged.
- Saturation: force stall_cnt to all-ones, hold a stall → stall_cnt stays all-ones. Assert rstn=0 mid-stall → outputs 0 with no clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard resolution.
// Define OPT_FWD_EN for EX/MEM bypass; otherwise dependencies stall.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic [7:0]       id_ctrl,
  input  logic             flush,
  input  logic [4:0]       e_rd,
  input  logic             e_we,
  input  logic             e_load,
  input  logic [XLEN-1:0]  e_res,
  input  logic [4:0]       m_rd,
  input  logic             m_we,
  input  logic [XLEN-1:0]  m_res,
  output logic             stall_o,
  output logic             q_valid,
  output logic [XLEN-1:0]  q_pc,
  output logic [XLEN-1:0]  q_op1,
  output logic [XLEN-1:0]  q_op2,
  output logic [XLEN-1:0]  q_imm,
  output logic [4:0]       q_rd,
  output logic             q_we,
  output logic             q_load,
  output logic [7:0]       q_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            me1, me2, mm1, mm2, hz;
  logic [XLEN-1:0] op1, op2;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  op1_q, op1_d;
  logic [XLEN-1:0]  op2_q, op2_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic             load_q, load_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign me1 = e_we & (e_rd == id_rs1) & (id_rs1 != 5'd0);
  assign me2 = e_we & (e_rd == id_rs2) & (id_rs2 != 5'd0);
  assign mm1 = m_we & (m_rd == id_rs1) & (id_rs1 != 5'd0);
  assign mm2 = m_we & (m_rd == id_rs2) & (id_rs2 != 5'd0);

`ifdef OPT_FWD_EN
  // EX beats MEM: the younger producer holds the live value
  assign op1 = (me1 & ~e_load) ? e_res : mm1 ? m_res : rf_rd1;
  assign op2 = (me2 & ~e_load) ? e_res : mm2 ? m_res : rf_rd2;
  assign hz  = id_valid & ((id_use1 & me1 & e_load) |
                           (id_use2 & me2 & e_load));
`else
  logic unused_fwd;
  assign unused_fwd = ^{e_res, m_res, e_load};
  assign op1 = rf_rd1;
  assign op2 = rf_rd2;
  assign hz  = id_valid & ((id_use1 & (me1 | mm1)) |
                           (id_use2 & (me2 | mm2)));
`endif

  // Gated by rstn so a reset mid-stall releases upstream at once
  assign stall_o = hz & ~flush & rstn;

  always_comb begin
    valid_d = id_valid;
    pc_d    = id_pc;
    op1_d   = op1;
    op2_d   = op2;
    imm_d   = id_imm;
    rd_d    = id_rd;
    we_d    = id_we & id_valid;
    load_d  = id_load & id_valid;
    ctrl_d  = id_ctrl;
    if (flush | stall_o) begin
      valid_d = 1'b0;
      pc_d    = '0;
      op1_d   = '0;
      op2_d   = '0;
      imm_d   = '0;
      rd_d    = '0;
      we_d    = 1'b0;
      load_d  = 1'b0;
      ctrl_d  = '0;
    end
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_valid   = valid_q;
  assign q_pc      = pc_q;
  assign q_op1     = op1_q;
  assign q_op2     = op2_q;
  assign q_imm     = imm_q;
  assign q_rd      = rd_q;
  assign q_we      = we_q;
  assign q_load    = load_q;
  assign q_ctrl    = ctrl_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (small stall counter to reach saturation).
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1, id_rs2;
  logic             id_use1, id_use2;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic [XLEN-1:0]  id_imm;
  logic [4:0]       id_rd;
  logic             id_we, id_load;
  logic [7:0]       id_ctrl;
  logic             flush;
  logic [4:0]       e_rd;
  logic             e_we, e_load;
  logic [XLEN-1:0]  e_res;
  logic [4:0]       m_rd;
  logic             m_we;
  logic [XLEN-1:0]  m_res;
  logic             stall_o;
  logic             q_valid;
  logic [XLEN-1:0]  q_pc, q_op1, q_op2, q_imm;
  logic [4:0]       q_rd;
  logic             q_we, q_load;
  logic [7:0]       q_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1),
    .id_use2(id_use2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .id_imm(id_imm), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .id_ctrl(id_ctrl), .flush(flush),
    .e_rd(e_rd), .e_we(e_we), .e_load(e_load), .e_res(e_res),
    .m_rd(m_rd), .m_we(m_we), .m_res(m_res), .stall_o(stall_o),
    .q_valid(q_valid), .q_pc(q_pc), .q_op1(q_op1), .q_op2(q_op2),
    .q_imm(q_imm), .q_rd(q_rd), .q_we(q_we), .q_load(q_load),
    .q_ctrl(q_ctrl), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs1 = 0; id_rs2 = 0;
    id_use1 = 0; id_use2 = 0; rf_rd1 = '0; rf_rd2 = '0;
    id_imm = '0; id_rd = 0; id_we = 0; id_load = 0; id_ctrl = 0;
    flush = 0; e_rd = 0; e_we = 0; e_load = 0; e_res = '0;
    m_rd = 0; m_we = 0; m_res = '0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 0;
    #12;
    total++;
    if (q_valid !== 1'b0 || stall_cnt !== 4'd0 || stall_o !== 1'b0)
      $display("FAIL reset: valid=%b cnt=%0d stall=%b want 0/0/0",
               q_valid, stall_cnt, stall_o);
    else passed++;
    rstn = 1;
    step();
    total++;
    if (q_valid !== 1'b0 || stall_cnt !== 4'd0)
      $display("FAIL reset_idle: valid=%b cnt=%0d want 0/0",
               q_valid, stall_cnt);
    else passed++;
  endtask

  task automatic test_alu_fwd();
    idle();
    id_valid = 1; id_rs1 = 5; id_use1 = 1; rf_rd1 = '0;
    e_rd = 5; e_we = 1; e_res = 32'h1234;
    #1;
`ifdef OPT_FWD_EN
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL alu_stall: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_op1 !== 32'h1234 || q_valid !== 1'b1)
      $display("FAIL alu_fwd: op1=%h valid=%b want 1234/1", q_op1, q_valid);
    else passed++;
`else
    total++;
    if (stall_o !== 1'b1)
      $display("FAIL alu_stall_e: got %b want 1", stall_o);
    else passed++;
    step(); bump();
    e_we = 0; m_rd = 5; m_we = 1; m_res = 32'h99;
    #1;
    total++;
    if (stall_o !== 1'b1 || q_valid !== 1'b0)
      $display("FAIL alu_stall_m: stall=%b valid=%b want 1/0",
               stall_o, q_valid);
    else passed++;
    step(); bump();
    m_we = 0; rf_rd1 = 32'h1234;
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL alu_release: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_op1 !== 32'h1234 || q_valid !== 1'b1)
      $display("FAIL alu_rf: op1=%h valid=%b want 1234/1", q_op1, q_valid);
    else passed++;
`endif
    total++;
    if (stall_cnt !== exp_cnt[3:0])
      $display("FAIL alu_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_priority();
    idle();
    id_valid = 1; id_rs2 = 7; id_use2 = 1; rf_rd2 = 32'hC;
    e_rd = 7; e_we = 1; e_res = 32'hA;
    m_rd = 7; m_we = 1; m_res = 32'hB;
    id_pc = 32'h100; id_imm = 32'h44; id_ctrl = 8'h5A; id_rd = 9;
    id_we = 1;
    #1;
`ifdef OPT_FWD_EN
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL prio_stall: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_op2 !== 32'hA)
      $display("FAIL prio_op2: got %h want a", q_op2);
    else passed++;
`else
    total++;
    if (stall_o !== 1'b1)
      $display("FAIL prio_stall: got %b want 1", stall_o);
    else passed++;
    step(); bump();
`endif
    id_rs2 = 0;
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL x0_stall: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_op2 !== 32'hC || q_pc !== 32'h100 || q_imm !== 32'h44 ||
        q_ctrl !== 8'h5A || q_rd !== 5'd9 || q_we !== 1'b1 ||
        q_load !== 1'b0)
      $display("FAIL x0_capture: op2=%h pc=%h imm=%h ctrl=%h rd=%0d we=%b ld=%b want c/100/44/5a/9/1/0",
               q_op2, q_pc, q_imm, q_ctrl, q_rd, q_we, q_load);
    else passed++;
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; id_rs1 = 3; id_use1 = 1; rf_rd1 = 32'h11;
    id_we = 1; id_load = 1; id_rd = 4;
    e_rd = 3; e_we = 1; e_load = 1; e_res = 32'hDEAD;
    #1;
    total++;
    if (stall_o !== 1'b1)
      $display("FAIL lu_stall: got %b want 1", stall_o);
    else passed++;
    step(); bump();
    total++;
    if (q_valid !== 1'b0 || q_we !== 1'b0 || stall_cnt !== exp_cnt[3:0])
      $display("FAIL lu_bubble: valid=%b we=%b cnt=%0d want 0/0/%0d",
               q_valid, q_we, stall_cnt, exp_cnt);
    else passed++;
    e_we = 0; e_load = 0;
    m_rd = 3; m_we = 1; m_res = 32'h55;
`ifndef OPT_FWD_EN
    step(); bump();
    m_we = 0; rf_rd1 = 32'h55;
`endif
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL lu_release: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_op1 !== 32'h55 || q_valid !== 1'b1 || q_load !== 1'b1 ||
        q_we !== 1'b1)
      $display("FAIL lu_op1: op1=%h valid=%b ld=%b we=%b want 55/1/1/1",
               q_op1, q_valid, q_load, q_we);
    else passed++;
  endtask

  task automatic test_idle_and_x0();
    idle();
    id_valid = 0; id_rs1 = 3; id_use1 = 1; id_we = 1; id_load = 1;
    e_rd = 3; e_we = 1; e_load = 1;
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL idle_stall: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_valid !== 1'b0 || q_we !== 1'b0 || q_load !== 1'b0)
      $display("FAIL idle_ctrl: valid=%b we=%b ld=%b want 0/0/0",
               q_valid, q_we, q_load);
    else passed++;
    id_valid = 1; id_rs1 = 0; rf_rd1 = 32'h77; e_rd = 0;
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL x0_load: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_valid !== 1'b1 || q_op1 !== 32'h77)
      $display("FAIL x0_op1: valid=%b op1=%h want 1/77", q_valid, q_op1);
    else passed++;
  endtask

  task automatic test_flush();
    idle();
    id_valid = 1; id_rs1 = 3; id_use1 = 1; id_we = 1; id_ctrl = 8'hFF;
    e_rd = 3; e_we = 1; e_load = 1;
    flush = 1;
    #1;
    total++;
    if (stall_o !== 1'b0)
      $display("FAIL flush_stall: got %b want 0", stall_o);
    else passed++;
    step();
    total++;
    if (q_valid !== 1'b0 || q_we !== 1'b0 || q_ctrl !== 8'h00 ||
        stall_cnt !== exp_cnt[3:0])
      $display("FAIL flush_bubble: valid=%b we=%b ctrl=%h cnt=%0d want 0/0/0/%0d",
               q_valid, q_we, q_ctrl, stall_cnt, exp_cnt);
    else passed++;
  endtask

  task automatic test_saturate();
    idle();
    id_valid = 1; id_rs2 = 12; id_use2 = 1;
    e_rd = 12; e_we = 1; e_load = 1;
    for (int i = 0; i < 20; i++) begin
      step(); bump();
    end
    total++;
    if (stall_cnt !== 4'hF || exp_cnt != 15)
      $display("FAIL sat_cnt: got %0d want 15", stall_cnt);
    else passed++;
    #2;
    rstn = 0;
    #1;
    total++;
    if (stall_o !== 1'b0 || stall_cnt !== 4'd0 || q_valid !== 1'b0)
      $display("FAIL rst_mid: stall=%b cnt=%0d valid=%b want 0/0/0",
               stall_o, stall_cnt, q_valid);
    else passed++;
    rstn = 1;
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_priority();
    test_load_use();
    test_idle_and_x0();
    test_flush();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
